// File: rtl/axi_uart_autobaud_pkg.sv
// Shared constants for the UART autobaud detector: FSM encoding and
// 8N1 sync-frame geometry.
package axi_uart_autobaud_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_STOPCHK = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  localparam logic [7:0] SYNC_BYTE  = 8'h55;
  localparam int         DATA_BITS  = 8;
  localparam int         FRAME_BITS = DATA_BITS + 2;

  // 0x55 has falling edges at start,d1,d3,d5,d7: four 2-bit intervals = 8 bit times.
  localparam int SYNC_EDGES = 5;
  localparam int TOTAL_BITS = 8;
  localparam int DIV_SHIFT  = 3;

endpackage

// File: rtl/axi_uart_autobaud_rx_sync.sv
// Two-flop synchronizer for an asynchronous UART line plus falling-edge
// detect on the synchronized value; idles high out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/axi_uart_autobaud.sv
// Measures a 0x55 sync character on rx and offers the derived clkdiv
// (clk cycles per bit) as a single-word stream result.
module axi_uart_autobaud
  import axi_uart_autobaud_pkg::*;
#(
  parameter int CW        = 16,
  parameter int MIN_DIV   = 4,
  parameter int MAX_DIV   = 4096,
  parameter int TOL_SHIFT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          rx,
  output logic [CW-1:0] o_tdata,
  output logic          o_tvalid,
  input  logic          o_tready,
  output logic          locked,
  output logic          error
);

  localparam int NW = CW + 2;
  localparam int TW = CW + 3;
  localparam int DW = CW + 1;
  localparam int SW = TW + 1;

  localparam logic [NW-1:0] CNT_MAX   = '1;
  localparam logic [TW-1:0] TOT_MAX   = '1;
  localparam logic [NW-1:0] IDLE_CYC  = NW'(MIN_DIV * FRAME_BITS);
  localparam logic [NW-1:0] TIMEOUT   = NW'(2 * MAX_DIV + MAX_DIV / 2);
  localparam logic [DW-1:0] DIV_LO    = DW'(MIN_DIV);
  localparam logic [DW-1:0] DIV_HI    = DW'(MAX_DIV);
  localparam logic [SW-1:0] ROUND     = SW'(TOTAL_BITS / 2);
  localparam logic [2:0]    LAST_EDGE = 3'(SYNC_EDGES - 1);

  logic rx_s, rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  logic [2:0]    state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] i1_q, i1_d;
  logic [TW-1:0] total_q, total_d;
  logic [2:0]    k_q, k_d;
  logic [CW-1:0] tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          locked_q, locked_d;
  logic          error_q, error_d;

  logic [NW-1:0] cnt_inc, diff, tol, samp;
  logic [TW:0]   total_sum;
  logic [TW-1:0] total_sat;
  logic [SW-1:0] div_sum;
  logic [DW-1:0] div;
  logic          div_bad;

  always_comb begin
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + NW'(1);
    diff      = (cnt_q >= i1_q) ? cnt_q - i1_q : i1_q - cnt_q;
    tol       = i1_q >> TOL_SHIFT;
    total_sum = {1'b0, total_q} + {2'b00, cnt_q};
    total_sat = total_sum[TW] ? TOT_MAX : total_sum[TW-1:0];
    // Round-to-nearest of total / 8 bit times.
    div_sum   = {1'b0, total_q} + ROUND;
    div       = div_sum[TW:DIV_SHIFT];
    div_bad   = (div < DIV_LO) || (div > DIV_HI);
    samp      = {1'b0, div} + {2'b00, div[DW-1:1]};
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i1_d     = i1_q;
    total_d  = total_q;
    k_d      = k_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    locked_d = locked_q;
    error_d  = 1'b0;

    if (!enable && state_q != ST_HOLD) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt_d = '0;
          end else if (cnt_q >= IDLE_CYC) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_ARMED: begin
          if (rx_fall) begin
            state_d = ST_MEASURE;
            cnt_d   = '0;
            k_d     = 3'd1;
            total_d = '0;
          end
        end
        ST_MEASURE: begin
          // An edge arriving on the timeout cycle still counts.
          if (rx_fall) begin
            cnt_d   = '0;
            k_d     = k_q + 3'd1;
            total_d = total_sat;
            if (k_q == 3'd1) i1_d = cnt_q;
            if (k_q != 3'd1 && diff > tol) begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end else if (k_q == LAST_EDGE) begin
              state_d = ST_STOPCHK;
            end
          end else if (cnt_q >= TIMEOUT) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_STOPCHK: begin
          if (div_bad) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q >= samp) begin
            cnt_d = '0;
            if (rx_s) begin
              state_d = ST_RESULT;
            end else begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RESULT: begin
          tdata_d  = div[CW-1:0];
          tvalid_d = 1'b1;
          locked_d = 1'b1;
          state_d  = ST_HOLD;
        end
        ST_HOLD: begin
          if (tvalid_q && o_tready) begin
            tvalid_d = 1'b0;
            state_d  = ST_IDLE;
            cnt_d    = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      i1_q     <= '0;
      total_q  <= '0;
      k_q      <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      i1_q     <= i1_d;
      total_q  <= total_d;
      k_q      <= k_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tvalid = tvalid_q;
  assign locked   = locked_q;
  assign error    = error_q;

endmodule

// File: tb/tb_axi_uart_autobaud.sv
// Scoreboard bench for axi_uart_autobaud: directed 8N1 frames on rx,
// expected clkdiv values queued at stimulus time and checked by a monitor.
`timescale 1ns/1ps
module tb_axi_uart_autobaud;
  import axi_uart_autobaud_pkg::*;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          rx;
  logic          o_tready;
  logic [CW-1:0] o_tdata;
  logic          o_tvalid;
  logic          locked;
  logic          error;

  int checks     = 0;
  int errors     = 0;
  int err_pulses = 0;
  logic [CW-1:0] exp_q[$];

  always #125 clk = ~clk;  // 4 MHz

  axi_uart_autobaud #(
    .CW(CW), .MIN_DIV(4), .MAX_DIV(4096), .TOL_SHIFT(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rx       (rx),
    .o_tdata  (o_tdata),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .locked   (locked),
    .error    (error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples just after the falling edge, ahead of the next active edge.
  always @(negedge clk) begin
    #1;
    if (rst && error) err_pulses++;
    if (rst && o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none", o_tdata);
      end else begin
        check("result", 32'(o_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int div, input int extra);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (div + (fr[i] ? 0 : extra)) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_err(input string name, input int target, input int budget);
    int n = 0;
    while (err_pulses < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, err_pulses, target);
  endtask

  initial begin
    #15_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; rx = 1'b1; o_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tdata",  32'(o_tdata),  0);
    check("rst_tvalid", 32'(o_tvalid), 0);
    check("rst_locked", 32'(locked),   0);
    check("rst_error",  32'(error),    0);
    rst = 1'b1; enable = 1'b1;
    idle(60);

    // 1: nominal 125000 baud
    exp_q.push_back(16'd32);
    send_byte(SYNC_BYTE, 32, 0);
    wait_drain("t1_drain", 200);
    check("t1_locked", 32'(locked), 1);
    check("t1_no_err", err_pulses, 0);

    // 2: clkdiv 33, then 67-cycle intervals both round to 33
    idle(60);
    exp_q.push_back(16'd33);
    send_byte(SYNC_BYTE, 33, 0);
    wait_drain("t2a_drain", 200);
    idle(60);
    exp_q.push_back(16'd33);
    send_byte(SYNC_BYTE, 33, 1);
    wait_drain("t2b_drain", 200);
    check("t2_no_err", err_pulses, 0);

    // 3: 0x00 has a single falling edge -> timeout
    idle(60);
    send_byte(8'h00, 32, 0);
    wait_err("t3_timeout", 1, 12000);
    check("t3_tvalid", 32'(o_tvalid), 0);

    // 4: too-fast rate, then an interval mismatch
    idle(60);
    send_byte(SYNC_BYTE, 2, 0);
    wait_err("t4_min_div", 2, 200);
    idle(60);
    send_byte(8'h57, 32, 0);
    wait_err("t4_mismatch", 3, 400);
    check("t4_tdata_kept", 32'(o_tdata), 33);

    // 5: held result ignores a second frame until accepted
    idle(60);
    o_tready = 1'b0;
    exp_q.push_back(16'd32);
    send_byte(SYNC_BYTE, 32, 0);
    idle(20);
    check("t5_hold_valid", 32'(o_tvalid), 1);
    check("t5_hold_data",  32'(o_tdata), 32);
    idle(60);
    send_byte(SYNC_BYTE, 40, 0);
    idle(20);
    check("t5_still_valid", 32'(o_tvalid), 1);
    check("t5_still_32",    32'(o_tdata), 32);
    check("t5_no_err",      err_pulses, 3);
    o_tready = 1'b1;
    wait_drain("t5_drain32", 10);
    check("t5_valid_drop", 32'(o_tvalid), 0);
    idle(60);
    exp_q.push_back(16'd40);
    send_byte(SYNC_BYTE, 40, 0);
    wait_drain("t5_drain40", 200);

    // 6: asynchronous reset in the middle of MEASURE
    idle(60);
    rx = 1'b0; repeat (32) @(negedge clk);
    rx = 1'b1; repeat (32) @(negedge clk);
    rx = 1'b0; repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_tdata",  32'(o_tdata),  0);
    check("t6_tvalid", 32'(o_tvalid), 0);
    check("t6_locked", 32'(locked),   0);
    check("t6_error",  32'(error),    0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(60);
    exp_q.push_back(16'd32);
    send_byte(SYNC_BYTE, 32, 0);
    wait_drain("t6_drain", 200);
    check("t6_relocked", 32'(locked), 1);

    idle(20);
    check("final_err_pulses", err_pulses, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
